// File: rtl/axis_pkg.sv
// Shared types and helpers for the frame-granular AXIS arbiter.
package axis_pkg;

    typedef enum logic {ST_IDLE, ST_LOCK} arb_state_t;

    localparam int MAX_PORTS = 16;

    function automatic int idw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First requester strictly after 'last', wrapping modulo n; returns 'last' when nobody requests.
    function automatic logic [3:0] rr_pick(input logic [MAX_PORTS-1:0] req,
                                           input logic [3:0] last,
                                           input int n);
        logic [3:0] pick;
        logic       found;
        logic [4:0] idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= MAX_PORTS; k++) begin
            idx = {1'b0, last} + 5'(k);
            if (32'(idx) >= n) idx = idx - 5'(n);
            if ((k <= n) && !found && req[idx[3:0]]) begin
                pick  = idx[3:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered buffer; output and input-ready come straight from flops.
module axis_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             out_ready_i
);

    logic [WIDTH-1:0] mem_q [2];
    logic             rd_ptr_q, wr_ptr_q;
    logic [1:0]       count_q, count_d;
    logic             ready_q;
    logic             push, pop;

    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = mem_q[rd_ptr_q];
    assign in_ready_o  = ready_q;
    assign pop         = out_valid_o & out_ready_i;
    assign push        = in_valid_i & ready_q;
    assign count_d     = count_q + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            count_q <= count_d;
            // ready looks one cycle ahead so a push can never land on a full buffer
            ready_q <= (count_d != 2'd2);
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) mem_q[wr_ptr_q] <= in_data_i;
    end

endmodule

// File: rtl/axis_frame_arbiter.sv
// N:1 AXI4-Stream arbiter with frame-granular round-robin and a registered output stage.
//   state   | meaning
//   ST_IDLE | no grant; pick next requester round-robin
//   ST_LOCK | grant held until the frame's last beat is accepted
module axis_frame_arbiter
    import axis_pkg::*;
#(
    parameter int NUM_PORTS   = 4,
    parameter int TDATA_WIDTH = 32,
    parameter int TUSER_WIDTH = 1,
    parameter int HAS_TLAST   = 1,
    localparam int IDW        = idw_of(NUM_PORTS)
) (
    input  logic                             aclk,
    input  logic                             areset,
    input  logic [NUM_PORTS*TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS*TUSER_WIDTH-1:0] s_axis_tuser,
    input  logic [NUM_PORTS-1:0]             s_axis_tlast,
    input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
    output logic [NUM_PORTS-1:0]             s_axis_tready,
    output logic [TDATA_WIDTH-1:0]           m_axis_tdata,
    output logic [TUSER_WIDTH-1:0]           m_axis_tuser,
    output logic                             m_axis_tlast,
    output logic [IDW-1:0]                   m_axis_tid,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             busy
);

    localparam int PW = IDW + 1 + TUSER_WIDTH + TDATA_WIDTH;

    arb_state_t       state_q, state_d;
    logic [IDW-1:0]   grant_q, grant_d;
    logic [IDW-1:0]   last_grant_q, last_grant_d;
    logic             skid_ready;
    logic             lock_valid;
    logic             push;
    logic             beat_last;
    logic [TDATA_WIDTH-1:0] sel_data;
    logic [TUSER_WIDTH-1:0] sel_user;
    logic [PW-1:0]    push_word, pop_word;

    assign sel_data   = s_axis_tdata[int'(grant_q)*TDATA_WIDTH +: TDATA_WIDTH];
    assign sel_user   = s_axis_tuser[int'(grant_q)*TUSER_WIDTH +: TUSER_WIDTH];
    assign beat_last  = (HAS_TLAST != 0) ? s_axis_tlast[grant_q] : 1'b1;
    assign lock_valid = (state_q == ST_LOCK) && s_axis_tvalid[grant_q];
    assign push       = lock_valid && skid_ready;
    assign push_word  = {grant_q, beat_last, sel_user, sel_data};
    assign busy       = (state_q == ST_LOCK);

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        s_axis_tready = '0;
        case (state_q)
            ST_IDLE: begin
                if (|s_axis_tvalid) begin
                    grant_d      = IDW'(rr_pick(MAX_PORTS'(s_axis_tvalid), 4'(last_grant_q), NUM_PORTS));
                    last_grant_d = grant_d;
                    state_d      = ST_LOCK;
                end
            end
            ST_LOCK: begin
                s_axis_tready[grant_q] = skid_ready;
                if (push && beat_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= IDW'(NUM_PORTS - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    axis_skid_buffer #(.WIDTH(PW)) u_skid (
        .clk         (aclk),
        .rst         (areset),
        .in_valid_i  (lock_valid),
        .in_data_i   (push_word),
        .in_ready_o  (skid_ready),
        .out_valid_o (m_axis_tvalid),
        .out_data_o  (pop_word),
        .out_ready_i (m_axis_tready)
    );

    assign {m_axis_tid, m_axis_tlast, m_axis_tuser, m_axis_tdata} = pop_word;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Self-checking bench: cycle table for reset/latency/arbitration, frame-level RR model for traffic.
module tb_axis_frame_arbiter;

    localparam int NP  = 4;
    localparam int DW  = 32;
    localparam int UW  = 1;
    localparam int IDW = 2;

    logic               aclk = 1'b0;
    logic               areset;
    logic [NP*DW-1:0]   s_tdata;
    logic [NP*UW-1:0]   s_tuser;
    logic [NP-1:0]      s_tlast, s_tvalid, s_tready;
    logic [DW-1:0]      m_tdata;
    logic [UW-1:0]      m_tuser;
    logic               m_tlast;
    logic [IDW-1:0]     m_tid;
    logic               m_tvalid, m_tready, busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    axis_frame_arbiter #(
        .NUM_PORTS(NP), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .HAS_TLAST(1)
    ) dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tuser(m_tuser), .m_axis_tlast(m_tlast),
        .m_axis_tid(m_tid), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .busy(busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] pd(input int p, input logic [31:0] b);
        return b ^ (32'(p) << 28);
    endfunction

    typedef struct {
        logic        rst;
        logic [3:0]  vld;
        logic [3:0]  lst;
        logic [31:0] dbase;
        logic        e_mv;
        logic [31:0] e_md;
        logic        e_ml;
        logic [1:0]  e_tid;
        logic [3:0]  e_sr;
        logic        e_busy;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic [3:0] vld, input logic [3:0] lst,
                                input logic [31:0] dbase, input logic e_mv, input logic [31:0] e_md,
                                input logic e_ml, input logic [1:0] e_tid, input logic [3:0] e_sr,
                                input logic e_busy);
        vec_t v;
        v.rst = rst; v.vld = vld; v.lst = lst; v.dbase = dbase;
        v.e_mv = e_mv; v.e_md = e_md; v.e_ml = e_ml; v.e_tid = e_tid; v.e_sr = e_sr; v.e_busy = e_busy;
        return v;
    endfunction

    typedef struct {
        logic [31:0]   d;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    typedef struct {
        logic [31:0]    d;
        logic [UW-1:0]  u;
        logic           l;
        logic [IDW-1:0] tid;
    } obeat_t;

    beat_t  pq [NP][$];
    obeat_t exp_q[$];

    task automatic do_reset();
        @(posedge aclk); #1;
        areset = 1'b1; s_tvalid = '0; s_tlast = '0; m_tready = 1'b1;
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        areset = 1'b0;
    endtask

    task automatic run_traffic(input int nfr, input int minl, input int maxl, input bit gaps, input int bp);
        int     gap[NP];
        int     len, guard, last_tl;
        bit     stalled, first_beat;
        obeat_t held, ob, eb;
        beat_t  bt;
        do_reset();
        exp_q.delete();
        for (int p = 0; p < NP; p++) begin
            pq[p].delete();
            gap[p] = 0;
        end
        // every port always has its next frame ready, so frames must emerge in strict port order
        for (int f = 0; f < nfr; f++) begin
            for (int p = 0; p < NP; p++) begin
                len = $urandom_range(maxl, minl);
                for (int b = 0; b < len; b++) begin
                    bt.d = $urandom; bt.u = UW'($urandom); bt.l = (b == len - 1);
                    pq[p].push_back(bt);
                    ob.d = bt.d; ob.u = bt.u; ob.l = bt.l; ob.tid = IDW'(p);
                    exp_q.push_back(ob);
                end
            end
        end
        guard = 0; stalled = 0; last_tl = -1; first_beat = 1; held = '{default: '0};
        while (exp_q.size() > 0 && guard < 4000) begin
            for (int p = 0; p < NP; p++) begin
                if (pq[p].size() > 0) begin
                    s_tdata[p*DW +: DW] = pq[p][0].d;
                    s_tuser[p*UW +: UW] = pq[p][0].u;
                    s_tlast[p]          = pq[p][0].l;
                    s_tvalid[p]         = (gap[p] == 0);
                end else begin
                    s_tvalid[p] = 1'b0;
                end
            end
            m_tready = (bp == 0) ? 1'b1 : (bp == 1) ? ((guard % 2) == 0) : ($urandom_range(2, 0) != 0);
            @(negedge aclk);
            check("tready_onehot", 64'($countones(s_tready) <= 1), 64'd1);
            if (stalled)
                check("stall_hold", {m_tvalid, m_tid, m_tlast, m_tuser, m_tdata},
                      {1'b1, held.tid, held.l, held.u, held.d});
            stalled = m_tvalid && !m_tready;
            held.d = m_tdata; held.u = m_tuser; held.l = m_tlast; held.tid = m_tid;
            if (m_tvalid && m_tready) begin
                eb = exp_q.pop_front();
                check("beat", {m_tid, m_tlast, m_tuser, m_tdata}, {eb.tid, eb.l, eb.u, eb.d});
                if (bp == 0 && !gaps && first_beat && last_tl >= 0)
                    check("bubble", 64'(cyc - last_tl), 64'd2);
                if (m_tlast) last_tl = cyc;
                first_beat = m_tlast;
            end
            for (int p = 0; p < NP; p++) begin
                if (gap[p] > 0) gap[p]--;
                else if (s_tvalid[p] && s_tready[p]) begin
                    bt = pq[p].pop_front();
                    if (gaps && !bt.l && $urandom_range(2, 0) == 0) gap[p] = $urandom_range(3, 1);
                end
            end
            guard++;
            @(posedge aclk); #1;
        end
        if (exp_q.size() > 0) check("traffic_timeout", 64'(exp_q.size()), 64'd0);
        s_tvalid = '0;
    endtask

    task automatic test_source_gap();
        int cnt, gapc, violated;
        bit p1_seen;
        do_reset();
        cnt = 0; gapc = 0; violated = 0; p1_seen = 0;
        for (int c = 0; c < 40 && !p1_seen; c++) begin
            s_tvalid[0] = (cnt < 4) && (gapc == 0);
            s_tdata[0 +: DW] = 32'h5000 + 32'(cnt);
            s_tlast[0] = (cnt == 3);
            s_tvalid[1] = 1'b1;
            s_tdata[DW +: DW] = 32'h5100;
            s_tlast[1] = 1'b1;
            @(negedge aclk);
            if (s_tready[1] && cnt < 4) violated++;
            if (gapc > 0 && !busy) violated++;
            if (gapc > 0) gapc--;
            else if (s_tvalid[0] && s_tready[0]) begin
                cnt++;
                if (cnt == 2) gapc = 3;
            end
            if (s_tvalid[1] && s_tready[1]) p1_seen = 1;
            @(posedge aclk); #1;
        end
        s_tvalid = '0;
        check("gap_no_preempt", 64'(violated), 64'd0);
        check("gap_p0_beats", 64'(cnt), 64'd4);
        check("gap_p1_granted", 64'(p1_seen), 64'd1);
    endtask

    task automatic test_mid_reset();
        int cnt;
        do_reset();
        m_tready = 1'b0;
        cnt = 0;
        for (int c = 0; c < 20 && cnt < 2; c++) begin
            s_tvalid[0] = 1'b1;
            s_tdata[0 +: DW] = 32'h6000 + 32'(cnt);
            s_tlast[0] = (cnt == 4);
            @(negedge aclk);
            if (s_tvalid[0] && s_tready[0]) cnt++;
            @(posedge aclk); #1;
        end
        s_tdata[0 +: DW] = 32'h6000 + 32'(cnt);
        @(negedge aclk);
        check("mrst_pre_valid", 64'(m_tvalid), 64'd1);
        @(posedge aclk); #1;
        areset = 1'b1;
        @(posedge aclk); #1;
        @(negedge aclk);
        check("mrst_mvalid", 64'(m_tvalid), 64'd0);
        check("mrst_sready", 64'(s_tready), 64'd0);
        check("mrst_busy", 64'(busy), 64'd0);
        @(posedge aclk); #1;
        areset = 1'b0; m_tready = 1'b1;
        s_tvalid = 4'b0011; s_tlast = 4'b0011;
        @(negedge aclk);
        check("mrst_no_stale", 64'(m_tvalid), 64'd0);
        @(posedge aclk); #1;
        @(negedge aclk);
        check("mrst_first_grant", 64'(s_tready), 64'd1);
        @(posedge aclk); #1;
        s_tvalid = '0;
    endtask

    vec_t tbl[18];

    initial begin
        tbl[0]  = mk(1, 4'hF, 4'h0, 32'h0,   0, 32'h0,            0, 2'd0, 4'h0, 0);
        tbl[1]  = mk(1, 4'hF, 4'h0, 32'h0,   0, 32'h0,            0, 2'd0, 4'h0, 0);
        tbl[2]  = mk(1, 4'hF, 4'h0, 32'h0,   0, 32'h0,            0, 2'd0, 4'h0, 0);
        tbl[3]  = mk(1, 4'hF, 4'h0, 32'h0,   0, 32'h0,            0, 2'd0, 4'h0, 0);
        tbl[4]  = mk(0, 4'h0, 4'h0, 32'h0,   0, 32'h0,            0, 2'd0, 4'h0, 0);
        tbl[5]  = mk(0, 4'h4, 4'h0, 32'hA00, 0, 32'h0,            0, 2'd0, 4'h0, 0);
        tbl[6]  = mk(0, 4'h4, 4'h0, 32'hA00, 0, 32'h0,            0, 2'd0, 4'h4, 1);
        tbl[7]  = mk(0, 4'h4, 4'h0, 32'hA01, 1, pd(2, 32'hA00),   0, 2'd2, 4'h4, 1);
        tbl[8]  = mk(0, 4'h4, 4'h4, 32'hA02, 1, pd(2, 32'hA01),   0, 2'd2, 4'h4, 1);
        tbl[9]  = mk(0, 4'h0, 4'h0, 32'h0,   1, pd(2, 32'hA02),   1, 2'd2, 4'h0, 0);
        tbl[10] = mk(0, 4'hB, 4'hF, 32'hB00, 0, 32'h0,            0, 2'd0, 4'h0, 0);
        tbl[11] = mk(0, 4'hB, 4'hF, 32'hB00, 0, 32'h0,            0, 2'd0, 4'h8, 1);
        tbl[12] = mk(0, 4'h3, 4'hF, 32'hB00, 1, pd(3, 32'hB00),   1, 2'd3, 4'h0, 0);
        tbl[13] = mk(0, 4'h3, 4'hF, 32'hB00, 0, 32'h0,            0, 2'd0, 4'h1, 1);
        tbl[14] = mk(0, 4'h2, 4'hF, 32'hB00, 1, pd(0, 32'hB00),   1, 2'd0, 4'h0, 0);
        tbl[15] = mk(0, 4'h2, 4'hF, 32'hB00, 0, 32'h0,            0, 2'd0, 4'h2, 1);
        tbl[16] = mk(0, 4'h0, 4'h0, 32'h0,   1, pd(1, 32'hB00),   1, 2'd1, 4'h0, 0);
        tbl[17] = mk(0, 4'h0, 4'h0, 32'h0,   0, 32'h0,            0, 2'd0, 4'h0, 0);

        areset = 1'b1; s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tuser = '0; m_tready = 1'b1;
        repeat (2) @(posedge aclk);

        for (int i = 0; i < 18; i++) begin
            @(posedge aclk); #1;
            areset   = tbl[i].rst;
            s_tvalid = tbl[i].vld;
            s_tlast  = tbl[i].lst;
            s_tuser  = 4'b1010;
            m_tready = 1'b1;
            for (int p = 0; p < NP; p++) s_tdata[p*DW +: DW] = pd(p, tbl[i].dbase);
            @(negedge aclk);
            check($sformatf("row%0d_sready", i), 64'(s_tready), 64'(tbl[i].e_sr));
            check($sformatf("row%0d_busy", i), 64'(busy), 64'(tbl[i].e_busy));
            check($sformatf("row%0d_mvalid", i), 64'(m_tvalid), 64'(tbl[i].e_mv));
            if (tbl[i].e_mv)
                check($sformatf("row%0d_mbeat", i), {m_tid, m_tlast, m_tdata},
                      {tbl[i].e_tid, tbl[i].e_ml, tbl[i].e_md});
        end

        run_traffic(6, 1, 5, 1, 2);
        run_traffic(4, 2, 2, 0, 0);
        run_traffic(3, 8, 8, 0, 1);
        test_source_gap();
        test_mid_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
